// File: rtl/ifc_chan_checker.sv
// ifc_chan_checker: N-channel value/struct consistency checker.
// Each channel's packed struct must equal {value + OFF_A, value + OFF_B}.
// Samples are registered, compared one cycle later, and mismatches feed
// saturating per-channel counters and sticky flags over a fixed-length run.
// Optional feature macro: IFC_CHK_STOP_EN (stop the run on the first mismatch).
module ifc_chan_checker #(
  parameter int NCHAN    = 2,
  parameter int WIDTH    = 32,
  parameter int OFF_A    = 100,
  parameter int OFF_B    = 200,
  parameter int TERM_CYC = 20,
  parameter int ERRW     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCHAN-1:0]           in_valid,
  input  logic [NCHAN*WIDTH-1:0]     in_value,
  input  logic [NCHAN*2*WIDTH-1:0]   in_struct,
  output logic [31:0]                cyc,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [NCHAN-1:0]           err_sticky,
  output logic [NCHAN*ERRW-1:0]      err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_FAIL
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  // Offsets are applied modulo 2^WIDTH, so truncate them once here.
  localparam logic [WIDTH-1:0] OFF_A_W = WIDTH'(OFF_A);
  localparam logic [WIDTH-1:0] OFF_B_W = WIDTH'(OFF_B);
  localparam logic [31:0]      TERM_W  = 32'(TERM_CYC);

  state_t           state_q, state_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [NCHAN-1:0] v_q;
  logic [WIDTH-1:0] val_q [NCHAN];
  pair_t            st_q  [NCHAN];
  logic [NCHAN-1:0] sticky_q, sticky_d;
  logic [ERRW-1:0]  cnt_q [NCHAN];
  logic [ERRW-1:0]  cnt_d [NCHAN];
  logic [NCHAN-1:0] mismatch;
  logic             capture;

  // Stage 1 only accepts samples on the IDLE->RUN edge and throughout RUN.
  assign capture = ((state_q == S_IDLE) && (|in_valid)) || (state_q == S_RUN);

  // Stage 2: compare each registered sample against its expected struct.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NCHAN; i++) begin
      mismatch[i] = v_q[i] &&
                    ((st_q[i].a != (val_q[i] + OFF_A_W)) ||
                     (st_q[i].b != (val_q[i] + OFF_B_W)));
    end
  end

  // Next-state and cycle counter; a stop-on-error FAIL overrides DONE.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (|in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_q == TERM_W) state_d = S_DONE;
`ifdef IFC_CHK_STOP_EN
        if (|mismatch) state_d = S_FAIL;
`endif
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Per-channel error bookkeeping; counters stick at all-ones.
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NCHAN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (mismatch[i]) begin
        sticky_d[i] = 1'b1;
        if (cnt_q[i] != {ERRW{1'b1}}) cnt_d[i] = cnt_q[i] + ERRW'(1);
      end
    end
  end

  // State and run-length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // Stage-1 sample registers; the valid bits drain to zero outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < NCHAN; i++) begin
        val_q[i] <= '0;
        st_q[i]  <= '0;
      end
    end else if (capture) begin
      v_q <= in_valid;
      for (int i = 0; i < NCHAN; i++) begin
        val_q[i] <= in_value[i*WIDTH +: WIDTH];
        st_q[i]  <= in_struct[i*2*WIDTH +: 2*WIDTH];
      end
    end else begin
      v_q <= '0;
    end
  end

  // Error counters and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
      for (int i = 0; i < NCHAN; i++) cnt_q[i] <= '0;
    end else begin
      sticky_q <= sticky_d;
      for (int i = 0; i < NCHAN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Pack the per-channel counters onto the flat output bus.
  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < NCHAN; i++) err_cnt[i*ERRW +: ERRW] = cnt_q[i];
  end

  assign cyc        = cyc_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err_sticky = sticky_q;

`ifdef IFC_CHK_STOP_EN
  assign fail = (state_q == S_FAIL);
`else
  assign fail = 1'b0;
`endif

endmodule
